// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue unit: accepts one instruction, reads the 8-entry register file,
// drives the combinational ALU, then writes back or resolves a BEQ.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | instr_ready=1, latch instr on instr_valid
//   S_ISSUE | decode, read regfile, register alu_op/alu_a/alu_b
//   S_EXEC  | operands stable on ALU, capture alu_res/alu_zero
//   S_WB    | regfile write, done pulse with br_taken/br_offset/illegal
module alu_issue_ctrl #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   output logic [2:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_res,
   input  logic              alu_zero,
   output logic              done,
   output logic              br_taken,
   output logic [DATA_W-1:0] br_offset,
   output logic              illegal,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_SLL  = 4'h2;
   localparam logic [3:0] OP_SRL  = 4'h3;
   localparam logic [3:0] OP_SRA  = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_BEQ  = 4'h6;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EXEC, S_WB} state_t;

   state_t              state, state_nxt;
   logic [15:0]         instr_q;
   logic [DATA_W-1:0]   rf [2**REG_AW];
   logic [DATA_W-1:0]   res_q;
   logic                zero_q;

   logic [3:0]          op_q;
   logic [REG_AW-1:0]   rd_a, rs_a, rt_a;
   logic [DATA_W-1:0]   imm_sext;
   logic [DATA_W-1:0]   rd_val, rs_val, rt_val;
   logic                dec_alu, dec_wr;
   logic [2:0]          dec_op;
   logic [DATA_W-1:0]   dec_b;

   assign op_q     = instr_q[15:12];
   assign rd_a     = instr_q[11:9];
   assign rs_a     = instr_q[8:6];
   assign rt_a     = instr_q[5:3];
   assign imm_sext = {{(DATA_W-6){instr_q[5]}}, instr_q[5:0]};

   // R0 is hard-wired to zero on every read port
   assign rd_val   = (rd_a == '0) ? '0 : rf[rd_a];
   assign rs_val   = (rs_a == '0) ? '0 : rf[rs_a];
   assign rt_val   = (rt_a == '0) ? '0 : rf[rt_a];
   assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

   always_comb begin
      dec_alu = 1'b0;
      dec_wr  = 1'b0;
      dec_op  = 3'b000;
      dec_b   = rt_val;
      case (op_q)
         OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA: begin
            dec_alu = 1'b1;
            dec_wr  = 1'b1;
            dec_op  = op_q[2:0];
         end
         OP_ADDI: begin
            dec_alu = 1'b1;
            dec_wr  = 1'b1;
            dec_b   = imm_sext;
         end
         OP_BEQ: begin
            dec_alu = 1'b1;
            dec_op  = 3'b001;
            dec_b   = rd_val;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      done        = 1'b0;
      br_taken    = 1'b0;
      br_offset   = '0;
      illegal     = 1'b0;
      case (state)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) state_nxt = S_ISSUE;
         end
         S_ISSUE: state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_WB;
         S_WB: begin
            done    = 1'b1;
            illegal = op_q[3];
            if (op_q == OP_BEQ) begin
               br_taken  = zero_q;
               br_offset = imm_sext;
            end
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOP and illegal opcodes leave the ALU operand registers untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= '0;
         alu_op  <= 3'b000;
         alu_a   <= '0;
         alu_b   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         for (int i = 0; i < 2**REG_AW; i++) rf[i] <= '0;
      end else begin
         case (state)
            S_IDLE: if (instr_valid) instr_q <= instr;
            S_ISSUE: begin
               if (dec_alu) begin
                  alu_op <= dec_op;
                  alu_a  <= rs_val;
                  alu_b  <= dec_b;
               end
            end
            S_EXEC: begin
               res_q  <= alu_res;
               zero_q <= alu_zero;
            end
            S_WB: if (dec_wr && rd_a != '0) rf[rd_a] <= res_q;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the DUT's ALU port plus an
// instruction-level reference model of the register file and retire outputs.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [2:0]  alu_op;
   logic [15:0] alu_a, alu_b, alu_res;
   logic        alu_zero;
   logic        done, br_taken, illegal;
   logic [15:0] br_offset;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] ref_rf [8];
   logic [2:0]  hold_op;
   logic [15:0] hold_a, hold_b;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.DATA_W(16), .REG_AW(3)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_res(alu_res), .alu_zero(alu_zero), .done(done), .br_taken(br_taken),
      .br_offset(br_offset), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a << b;
         3'b011:  return a >> b;
         3'b100:  return $unsigned($signed(a) >>> b);
         default: return 16'h0000;
      endcase
   endfunction

   assign alu_res  = alu_fn(alu_op, alu_a, alu_b);
   assign alu_zero = (alu_a == alu_b);

   function automatic logic [15:0] rt_i(input int op, input int rd, input int rs, input int rt);
      return {op[3:0], rd[2:0], rs[2:0], rt[2:0], 3'b000};
   endfunction

   function automatic logic [15:0] it_i(input int op, input int rd, input int rs, input int imm);
      return {op[3:0], rd[2:0], rs[2:0], imm[5:0]};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0000;
      hold_op = 3'b000;
      hold_a  = 16'h0000;
      hold_b  = 16'h0000;
   endtask

   task automatic check_rf(input string tag);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = i[2:0];
         #1;
         vectors++;
         if (dbg_data !== ref_rf[i]) begin
            miscompares++;
            $display("FAIL %s rf[%0d]: got %h expected %h", tag, i, dbg_data, ref_rf[i]);
         end
      end
   endtask

   task automatic check_reg(input string tag, input int r, input logic [15:0] exp);
      dbg_addr = r[2:0];
      #1;
      vectors++;
      if (dbg_data !== exp) begin
         miscompares++;
         $display("FAIL %s R%0d: got %h expected %h", tag, r, dbg_data, exp);
      end
   endtask

   // One full instruction, checked cycle by cycle against the model.
   task automatic run_instr(input logic [15:0] ins, input bit hold);
      int          op, rd, rs, rt, waited;
      logic [15:0] sx, ea, eb, eres, eoff;
      logic [2:0]  eop;
      bit          uses_alu, wr, beq, ill, etaken;
      op = ins[15:12]; rd = ins[11:9]; rs = ins[8:6]; rt = ins[5:3];
      sx = {{10{ins[5]}}, ins[5:0]};
      uses_alu = 1; wr = 0; beq = 0; ill = 0;
      eop = 3'b000; ea = ref_rf[rs]; eb = ref_rf[rt];
      if (op <= 4) begin eop = op[2:0]; wr = 1; end
      else if (op == 5) begin eb = sx; wr = 1; end
      else if (op == 6) begin eop = 3'b001; eb = ref_rf[rd]; beq = 1; end
      else begin uses_alu = 0; ill = (op >= 8); end
      if (uses_alu) begin hold_op = eop; hold_a = ea; hold_b = eb; end
      eres   = alu_fn(hold_op, hold_a, hold_b);
      etaken = beq && (hold_a == hold_b);
      eoff   = beq ? sx : 16'h0000;

      waited = 0;
      while (instr_ready !== 1'b1 && waited < 10) begin
         @(posedge clk); #1; waited++;
      end
      vectors++;
      if (instr_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_wait: got %b expected 1", instr_ready);
      end

      @(negedge clk); instr_valid = 1'b1; instr = ins;
      @(posedge clk); #1;
      vectors++;
      if (instr_ready !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL issue_cycle %h: ready=%b done=%b expected 0 0", ins, instr_ready, done);
      end
      if (hold) instr = it_i(5, 7, 0, 1);
      else instr_valid = 1'b0;

      @(posedge clk); #1;
      vectors++;
      if (alu_op !== hold_op || alu_a !== hold_a || alu_b !== hold_b || done !== 1'b0 || instr_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL exec_cycle %h: op=%b a=%h b=%h done=%b rdy=%b expected %b %h %h 0 0",
                  ins, alu_op, alu_a, alu_b, done, instr_ready, hold_op, hold_a, hold_b);
      end

      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b1 || br_taken !== etaken || br_offset !== eoff || illegal !== ill || instr_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL wb_cycle %h: done=%b taken=%b off=%h ill=%b rdy=%b expected 1 %b %h %b 0",
                  ins, done, br_taken, br_offset, illegal, instr_ready, etaken, eoff, ill);
      end
      instr_valid = 1'b0;
      instr = 16'($urandom);
      if (wr && rd != 0) ref_rf[rd] = eres;

      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || instr_ready !== 1'b1 || br_taken !== 1'b0 || br_offset !== 16'h0 || illegal !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after %h: done=%b rdy=%b taken=%b off=%h ill=%b expected 0 1 0 0000 0",
                  ins, done, instr_ready, br_taken, br_offset, illegal);
      end
      check_rf("after_instr");
   endtask

   task automatic test_reset();
      rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0; dbg_addr = 3'd0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (alu_op !== 3'b000 || alu_a !== 16'h0 || alu_b !== 16'h0 || done !== 1'b0 ||
          br_taken !== 1'b0 || br_offset !== 16'h0 || illegal !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: op=%b a=%h b=%h done=%b taken=%b off=%h ill=%b expected all 0",
                  alu_op, alu_a, alu_b, done, br_taken, br_offset, illegal);
      end
      check_rf("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (instr_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b expected 1", instr_ready);
      end
   endtask

   task automatic test_addi();
      run_instr(it_i(5, 1, 0, 5), 0);
      run_instr(it_i(5, 2, 0, -3), 0);
      check_reg("addi", 1, 16'h0005);
      check_reg("addi", 2, 16'hFFFD);
   endtask

   task automatic test_add_sub();
      run_instr(rt_i(0, 3, 1, 2), 0);
      run_instr(rt_i(1, 4, 2, 1), 0);
      check_reg("add", 3, 16'h0002);
      check_reg("sub", 4, 16'hFFF8);
   endtask

   task automatic test_shifts();
      // build R5 = 0xECAD from 5-bit chunks: 1 | 11011 | 00101 | 01101
      run_instr(it_i(5, 5, 0, 1), 0);
      run_instr(it_i(5, 6, 0, 5), 0);
      run_instr(rt_i(2, 5, 5, 6), 0);
      run_instr(it_i(5, 5, 5, 27), 0);
      run_instr(rt_i(2, 5, 5, 6), 0);
      run_instr(it_i(5, 5, 5, 5), 0);
      run_instr(rt_i(2, 5, 5, 6), 0);
      run_instr(it_i(5, 5, 5, 13), 0);
      run_instr(it_i(5, 6, 0, 3), 0);
      check_reg("build", 5, 16'hECAD);
      run_instr(rt_i(2, 7, 5, 6), 0);
      check_reg("sll", 7, 16'h6568);
      run_instr(rt_i(3, 7, 5, 6), 0);
      check_reg("srl", 7, 16'h1D95);
      run_instr(rt_i(4, 7, 5, 6), 0);
      check_reg("sra", 7, 16'hFD95);
   endtask

   task automatic test_beq();
      run_instr(it_i(6, 1, 1, -4), 0);
      run_instr(it_i(6, 2, 1, 9), 0);
   endtask

   task automatic test_r0_illegal_hold();
      run_instr(it_i(5, 0, 0, 7), 0);
      check_reg("r0", 0, 16'h0000);
      run_instr(rt_i(10, 3, 1, 2), 0);
      run_instr(rt_i(7, 3, 1, 2), 0);
      run_instr(it_i(5, 3, 3, 1), 1);
      check_reg("hold", 7, 16'hFD95);
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         int op;
         op = ($urandom_range(0, 3) == 0) ? 5 : int'($urandom_range(0, 15));
         run_instr({op[3:0], 12'($urandom)}, bit'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk); instr_valid = 1'b1; instr = it_i(5, 1, 1, 9);
      @(posedge clk); #1; instr_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (done !== 1'b0 || instr_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid_out: done=%b rdy=%b expected 0 1", done, instr_ready);
      end
      model_clear();
      check_rf("reset_mid");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (instr_ready !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_release: rdy=%b done=%b expected 1 0", instr_ready, done);
      end
      check_rf("reset_mid_release");
      run_instr(rt_i(0, 2, 1, 1), 0);
   endtask

   initial begin
      test_reset();
      test_addi();
      test_add_sub();
      test_shifts();
      test_beq();
      test_r0_illegal_hold();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
